csla_pipe: RTL and testbench
============================

Name: csla_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 4-bit combinational CSLA.
- Operand width is split into BLK-bit blocks, with one pipeline stage per block. Each stage precomputes its block sum for carry-in 0 and 1, then selects using the registered carry from the previous stage.
- Valid/ready handshake on both sides, so it drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BLK and at least BLK.
- BLK, 4, carry-select block width in bits; NSTG = WIDTH/BLK pipeline stages.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 = A+B+cin; 1 = A-B, computed as A + ~B + 1.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, async): every stage valid bit, sum, cout, ovf and out_valid go to 0 immediately. In-flight beats are discarded, with no partial output. First accept is possible on the first clk edge after rst_n deasserts.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_ready/out_valid.
- Accept: when in_valid && in_ready at a rising edge, the beat is captured into stage 0. Captured fields are the effective B (b, or ~b if sub), the effective carry (cin, or 1 if sub), and the operand slices.
- Stage k (0..NSTG-1) does the following:
  - Computes block k with both carry hypotheses, i.e. s0/c0 for carry-in 0 and s1/c1 for carry-in 1.
  - Selects using the carry registered by stage k-1; stage 0 uses the captured effective carry.
  - Registers the selected slice, the carry, and all not-yet-consumed upper operand slices. Lower result slices already computed are forwarded unchanged.
- The last stage also registers ovf. It uses the carry into bit WIDTH-1, derived from the top block's internal ripple.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+NSTG, provided adv held every cycle. Throughput is one beat per cycle.
- Stall: when adv=0, all stage registers hold, in_ready=0, and out_valid/sum/cout/ovf stay stable until out_ready.
- Bubbles: a stage whose valid bit is 0 still shifts on adv. Bubbles propagate, and empty stages are never compacted. Beats are never reordered, dropped or duplicated.
- Simultaneous events: out_ready && out_valid in the same cycle as in_valid allows accept and retire on the same edge.
- When out_valid=0, the sum/cout/ovf values are don't-care, but must not be X after reset.
- Arithmetic wrap-around: sum is modulo 2^WIDTH; cout carries the overflow bit.
- Elaboration: if WIDTH % BLK != 0 or BLK < 1, issue a compile-time error, e.g. a generate-time $error.

Decomposition:
- Shared package csla_pkg: the function computing NSTG from WIDTH/BLK, and the default widths. No typedefs are needed beyond a stage-register struct if the codebase uses SV.
- Sub-module csla_block (parameter BLK, purely combinational): inputs a_blk, b_blk, sel_c; outputs s, c_out, c_msb_in. Internally it is two ripple adders (carry-in 0 and 1) plus a mux. csla_pipe instantiates NSTG copies inside a generate loop, with pipeline registers around them.

Test Plan (WIDTH=16, BLK=4, latency 4):
- Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0, sum=0 immediately. After release, no stale beat ever emerges.
- a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 6 beats back-to-back (0x1111+0x1111 ... 0x6666+0x1111), and hold out_ready=0 for 3 cycles once the first result is valid -> in_ready=0 during the stall, outputs stable. All 6 results (0x2222 ... 0x7777) emerge in order with no gaps after release.
- Random: 10k beats with random in_valid/out_ready and random sub -> every output matches a scoreboard model of {cout,sum} = a ± b (+cin), and ovf matches the reference computation.

Source files
------------

// File: rtl/csla_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
package csla_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BLK   = 4;

    // Number of carry-select stages; guards against a zero block width so the
    // elaboration check in the top can report the bad configuration itself.
    function automatic int calc_nstg(input int width, input int blk);
        return (blk < 1) ? 1 : width / blk;
    endfunction

endpackage

// File: rtl/csla_pipe_if.sv
// Streaming operand/result bus of csla_pipe: valid/ready on both sides.
interface csla_pipe_if
    import csla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/csla_block.sv
// One carry-select block: two ripple adders (carry-in 0 and 1) and a mux.
module csla_block
    import csla_pkg::*;
#(
    parameter int BLK = DEF_BLK
) (
    input  logic [BLK-1:0] a_blk,
    input  logic [BLK-1:0] b_blk,
    input  logic           sel_c,
    output logic [BLK-1:0] s,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;
    logic [BLK:0]   c0;
    logic [BLK:0]   c1;

    // Both ripple chains evaluated up front so the late carry only drives a mux.
    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = a_blk[i] ^ b_blk[i] ^ c0[i];
            c0[i+1] = (a_blk[i] & b_blk[i]) | (c0[i] & (a_blk[i] ^ b_blk[i]));
            s1[i]   = a_blk[i] ^ b_blk[i] ^ c1[i];
            c1[i+1] = (a_blk[i] & b_blk[i]) | (c1[i] & (a_blk[i] ^ b_blk[i]));
        end
    end

    assign s        = sel_c ? s1 : s0;
    assign c_out    = sel_c ? c1[BLK] : c0[BLK];
    // Carry into the block MSB; at the top block this feeds overflow detection.
    assign c_msb_in = sel_c ? c1[BLK-1] : c0[BLK-1];

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor, one pipeline stage per BLK-bit block.
// Rank 0 holds the captured beat (effective B and carry); rank k+1 holds the
// result slices 0..k and the carry out of block k. All ranks advance together
// on adv, so bubbles travel with the stream and order is preserved.
module csla_pipe
    import csla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLK   = DEF_BLK
) (
    input logic        clk,
    input logic        rst_n,
    csla_pipe_if.slave bus
);

    localparam int NSTG = calc_nstg(WIDTH, BLK);

    if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK) != 0) begin : g_bad_cfg
        $error("csla_pipe: WIDTH (%0d) must be a positive multiple of BLK (%0d)", WIDTH, BLK);
    end

    logic             vld_q [0:NSTG];
    logic [WIDTH-1:0] a_q   [0:NSTG];
    logic [WIDTH-1:0] b_q   [0:NSTG];
    logic             cy_q  [0:NSTG];
    logic [WIDTH-1:0] res_q [1:NSTG];
    logic             ovf_q;

    logic [BLK-1:0]   blk_s [NSTG];
    logic             blk_c [NSTG];
    logic             blk_m [NSTG];

    logic             adv;

    // A single enable for the whole pipe: move whenever the output slot frees up.
    assign adv           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = adv;

    assign bus.out_valid = vld_q[NSTG];
    assign bus.sum       = res_q[NSTG];
    assign bus.cout      = cy_q[NSTG];
    assign bus.ovf       = ovf_q;

    // Capture rank: subtraction is folded in as A + ~B + 1 so every stage only adds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q[0] <= 1'b0;
            a_q[0]   <= '0;
            b_q[0]   <= '0;
            cy_q[0]  <= 1'b0;
        end else if (adv) begin
            vld_q[0] <= bus.in_valid;
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.sub ? ~bus.b : bus.b;
            cy_q[0]  <= bus.sub | bus.cin;
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] res_prev;
        logic [WIDTH-1:0] res_nxt;

        if (k == 0) begin : g_first
            assign res_prev = '0;
        end else begin : g_next
            assign res_prev = res_q[k];
        end

        csla_block #(
            .BLK (BLK)
        ) u_blk (
            .a_blk    (a_q[k][k*BLK +: BLK]),
            .b_blk    (b_q[k][k*BLK +: BLK]),
            .sel_c    (cy_q[k]),
            .s        (blk_s[k]),
            .c_out    (blk_c[k]),
            .c_msb_in (blk_m[k])
        );

        // Lower slices pass through untouched; only block k's slice is filled in.
        always_comb begin
            res_nxt                = res_prev;
            res_nxt[k*BLK +: BLK]  = blk_s[k];
        end

        // Advance rank k+1 from rank k; empty ranks shift as well.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[k+1] <= 1'b0;
                a_q[k+1]   <= '0;
                b_q[k+1]   <= '0;
                cy_q[k+1]  <= 1'b0;
                res_q[k+1] <= '0;
            end else if (adv) begin
                vld_q[k+1] <= vld_q[k];
                a_q[k+1]   <= a_q[k];
                b_q[k+1]   <= b_q[k];
                cy_q[k+1]  <= blk_c[k];
                res_q[k+1] <= res_nxt;
            end
        end
    end

    // Overflow registered alongside the last stage: carry into MSB xor carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= blk_m[NSTG-1] ^ blk_c[NSTG-1];
        end
    end

endmodule

// File: tb/tb_csla_pipe.sv
// Self-checking bench for csla_pipe (WIDTH=16, BLK=4): directed vectors with
// literal expectations, backpressure and reset scenarios, and a random stream
// checked against an integer-arithmetic scoreboard.
module tb_csla_pipe;

    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int LAT   = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    csla_pipe_if #(.WIDTH(WIDTH)) bus ();

    csla_pipe #(
        .WIDTH (WIDTH),
        .BLK   (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference result from plain integer arithmetic on the operand values.
    function automatic res_t ref_model(input logic [15:0] a, input logic [15:0] b,
                                       input logic cin, input logic sub);
        res_t   r;
        longint ua, ub, sa, sb, u, s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u      = ua - ub;
            s      = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + longint'(cin);
            s      = sa + sb + longint'(cin);
            r.cout = (u > 65535);
        end
        r.sum = u[15:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard bookkeeping on the handshakes seen at each clock edge.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_model(bus.a, bus.b, bus.cin, bus.sub));
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Output comparison on the falling edge, every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: actual out_valid=1 sum=%h, required no pending result", bus.sum);
                end else begin
                    chk("scoreboard", 32'({bus.sum, bus.cout, bus.ovf}), 32'(exp_q[0]));
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub);
        int   n;
        logic acc;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        n            = 0;
        do begin
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: actual in_ready=0 for %0d cycles, required accept", n);
        end
    endtask

    task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] esum, input logic ecout, input logic eovf);
        res_t m;
        int   lat;
        m = ref_model(a, b, cin, sub);
        chk({name, "_model_sum"},  32'(m.sum),  32'(esum));
        chk({name, "_model_cout"}, 32'(m.cout), 32'(ecout));
        chk({name, "_model_ovf"},  32'(m.ovf),  32'(eovf));
        bus.out_ready = 1'b1;
        send_beat(a, b, cin, sub);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 12) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_sum"},  32'(bus.sum),  32'(esum));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ecout));
        chk({name, "_ovf"},  32'(bus.ovf),  32'(eovf));
        step();
    endtask

    task automatic backpressure();
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send_beat(16'(32'h1111 * i), 16'h1111, 1'b0, 1'b0);
                bus.in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!bus.out_valid && w < 20) begin
                    step();
                    w++;
                end
                chk("bp_first_latency", 32'(w), 32'(LAT + 1));
                bus.out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    #1;
                    chk("bp_in_ready_stall", 32'(bus.in_ready), 32'(0));
                    @(posedge clk);
                    #1;
                    chk("bp_hold_valid", 32'(bus.out_valid), 32'(1));
                    chk("bp_hold_sum", 32'(bus.sum), 32'h2222);
                end
                bus.out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    chk("bp_valid", 32'(bus.out_valid), 32'(1));
                    chk("bp_order", 32'(bus.sum), 32'h1111 * (i + 2));
                    step();
                end
            end
        join
    endtask

    task automatic midstream_reset();
        int seen;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send_beat(16'(32'h0100 * i), 16'h0003, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk("pre_reset_valid", 32'(bus.out_valid), 32'(1));
        chk("pre_reset_sum", 32'(bus.sum), 32'h0103);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_async_sum", 32'(bus.sum), 32'(0));
        chk("rst_async_cout", 32'(bus.cout), 32'(0));
        chk("rst_async_ovf", 32'(bus.ovf), 32'(0));
        step();
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            step();
            if (bus.out_valid) seen++;
        end
        chk("no_stale_beat", 32'(seen), 32'(0));
    endtask

    task automatic random_run();
        int acc, cyc;
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.a         = pick();
            bus.b         = pick();
            bus.cin       = 1'($urandom_range(0, 1));
            bus.sub       = 1'($urandom_range(0, 1));
            #1;
            if (bus.in_valid && bus.in_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("random_beats", 32'(acc), 32'(10000));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_sum", 32'(bus.sum), 32'(0));
        chk("reset_cout", 32'(bus.cout), 32'(0));
        chk("reset_ovf", 32'(bus.ovf), 32'(0));
        chk("reset_in_ready", 32'(bus.in_ready), 32'(1));
        rst_n = 1'b1;

        directed("add_00ff",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        directed("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_zero",  16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        backpressure();
        midstream_reset();
        random_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: actual run still active at %0t, required completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
